spi_tx_arbiter: RTL and testbench

SPI_TX_ARBITER -- requirements
Module: spi_tx_arbiter

---
 rtl/spi_tx_arbiter_pkg.sv | 27 ++
 rtl/spi_tx_arbiter_spi_tx.sv | 60 ++++++
 rtl/spi_tx_arbiter.sv | 132 +++++++++++++
 tb/tb_spi_tx_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_tx_arbiter_pkg.sv
// rtl/spi_tx_arbiter_pkg.sv - shared types and width helpers for the SPI transmit arbiter
package spi_tx_arbiter_pkg;

  typedef logic [31:0] data_t;

  typedef struct packed {
    logic [10:0] x;
    logic [9:0]  y;
  } location_t;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_START,
    WAIT_DONE,
    GAP
  } arb_state_t;

  function automatic int id_width(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  function automatic int frame_width(input int num_req, input int payload_width);
    return id_width(num_req) + payload_width;
  endfunction

endpackage

// File: rtl/spi_tx_arbiter_spi_tx.sv
// rtl/spi_tx_arbiter_spi_tx.sv - MSB-first SPI transmitter, data changes on the falling serial clock edge
module spi_tx #(
  parameter int DATA_WIDTH  = 8,
  parameter int DATA_PERIOD = 100
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  trigger_in,
  output logic                  data_out,
  output logic                  data_clk_out,
  output logic                  sel_out
);

  localparam int HALF   = (DATA_PERIOD / 2 > 0) ? DATA_PERIOD / 2 : 1;
  localparam int HALF_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic [DATA_WIDTH-1:0] shift;
  logic [HALF_W-1:0]     half_cnt;
  logic [BIT_W-1:0]      bit_cnt;

  // The bit on the wire is always the top of the shift register.
  assign data_out = shift[DATA_WIDTH-1];

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sel_out      <= 1'b1;
      data_clk_out <= 1'b0;
      shift        <= '0;
      half_cnt     <= '0;
      bit_cnt      <= '0;
    end else if (sel_out) begin
      if (trigger_in) begin
        sel_out      <= 1'b0;
        shift        <= data_in;
        half_cnt     <= '0;
        bit_cnt      <= '0;
        data_clk_out <= 1'b0;
      end
    end else if (half_cnt != HALF_W'(HALF - 1)) begin
      half_cnt <= half_cnt + 1'b1;
    end else begin
      half_cnt <= '0;
      if (!data_clk_out) begin
        data_clk_out <= 1'b1;
      end else begin
        data_clk_out <= 1'b0;
        if (bit_cnt == BIT_W'(DATA_WIDTH - 1)) begin
          sel_out <= 1'b1;
          shift   <= '0;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
          shift   <= {shift[DATA_WIDTH-2:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: rtl/spi_tx_arbiter.sv
// rtl/spi_tx_arbiter.sv - round-robin arbiter that serialises one requester frame at a time over spi_tx
module spi_tx_arbiter
  import spi_tx_arbiter_pkg::*;
#(
  parameter int  NUM_REQ        = 2,
  parameter int  PAYLOAD_WIDTH  = 32,
  parameter int  DATA_PERIOD    = 100,
  parameter int  GAP_CYCLES     = 16,
  parameter int  TIMEOUT_CYCLES = 8192,
  localparam int ID_W           = id_width(NUM_REQ),
  localparam int FRAME_W        = frame_width(NUM_REQ, PAYLOAD_WIDTH)
) (
  input  logic                                   clk_pixel_in,
  input  logic                                   rst_in,
  input  logic [NUM_REQ-1:0]                     req_valid_in,
  input  logic [NUM_REQ-1:0][PAYLOAD_WIDTH-1:0]  req_data_in,
  output logic [NUM_REQ-1:0]                     req_ready_out,
  output logic                                   data_out,
  output logic                                   data_clk_out,
  output logic                                   sel_out,
  output logic                                   busy_out,
  output logic [ID_W-1:0]                        grant_id_out,
  output logic                                   timeout_out
);

  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

  arb_state_t         state;
  logic [ID_W-1:0]    last_grant;
  logic [FRAME_W-1:0] frame;
  logic               trigger;
  logic [WD_W-1:0]    wd_cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic               any_req;
  logic [ID_W-1:0]    pick;
  logic [ID_W-1:0]    cand;
  logic               spi_rst;

  // Walk from the farthest candidate to the nearest so the nearest valid one wins.
  always_comb begin
    any_req = 1'b0;
    pick    = '0;
    cand    = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = ID_W'((int'(last_grant) + i) % NUM_REQ);
      if (req_valid_in[cand]) begin
        any_req = 1'b1;
        pick    = cand;
      end
    end
  end

  always_ff @(posedge clk_pixel_in) begin
    if (rst_in) begin
      state         <= IDLE;
      last_grant    <= ID_W'(NUM_REQ - 1);
      grant_id_out  <= '0;
      req_ready_out <= '0;
      busy_out      <= 1'b0;
      timeout_out   <= 1'b0;
      trigger       <= 1'b0;
      frame         <= '0;
      wd_cnt        <= '0;
      gap_cnt       <= '0;
    end else begin
      req_ready_out <= '0;
      timeout_out   <= 1'b0;
      trigger       <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            frame               <= {pick, req_data_in[pick]};
            req_ready_out[pick] <= 1'b1;
            grant_id_out        <= pick;
            last_grant          <= pick;
            trigger             <= 1'b1;
            busy_out            <= 1'b1;
            state               <= LAUNCH;
          end
        end
        LAUNCH: begin
          wd_cnt <= '0;
          state  <= WAIT_START;
        end
        WAIT_START, WAIT_DONE: begin
          wd_cnt <= wd_cnt + 1'b1;
          // Watchdog wins over a same-cycle completion; both lead to GAP anyway.
          if (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
            timeout_out <= 1'b1;
            gap_cnt     <= '0;
            state       <= GAP;
          end else if (state == WAIT_START && !sel_out) begin
            state <= WAIT_DONE;
          end else if (state == WAIT_DONE && sel_out) begin
            gap_cnt <= '0;
            state   <= GAP;
          end
        end
        GAP: begin
          if (GAP_CYCLES <= 1 || gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
            busy_out <= 1'b0;
            state    <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: begin
          busy_out <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  // A watchdog abort also resets the shifter so the wire goes quiet during GAP.
  assign spi_rst = rst_in | timeout_out;

  spi_tx #(
    .DATA_WIDTH  (FRAME_W),
    .DATA_PERIOD (DATA_PERIOD)
  ) u_spi_tx (
    .clk_in       (clk_pixel_in),
    .rst_in       (spi_rst),
    .data_in      (frame),
    .trigger_in   (trigger),
    .data_out     (data_out),
    .data_clk_out (data_clk_out),
    .sel_out      (sel_out)
  );

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// tb/tb_spi_tx_arbiter.sv - randomized self-checking bench for spi_tx_arbiter
module tb_spi_tx_arbiter;

  localparam int NREQ = 2;
  localparam int DP   = 4;
  localparam int GAPC = 16;
  localparam int TMO  = 50;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [1:0]       valid;
  logic [1:0][31:0] data;
  logic [1:0]       ready;
  logic             sdata, dclk, sel, busy, tmo;
  logic [0:0]       gid;

  logic [1:0]       valid2;
  logic [1:0][31:0] data2;
  logic [1:0]       ready2;
  logic             sdata2, dclk2, sel2, busy2, tmo2;
  logic [0:0]       gid2;

  spi_tx_arbiter #(
    .NUM_REQ(NREQ), .PAYLOAD_WIDTH(32), .DATA_PERIOD(DP),
    .GAP_CYCLES(GAPC), .TIMEOUT_CYCLES(8192)
  ) dut (
    .clk_pixel_in(clk), .rst_in(rst), .req_valid_in(valid), .req_data_in(data),
    .req_ready_out(ready), .data_out(sdata), .data_clk_out(dclk), .sel_out(sel),
    .busy_out(busy), .grant_id_out(gid), .timeout_out(tmo)
  );

  spi_tx_arbiter #(
    .NUM_REQ(NREQ), .PAYLOAD_WIDTH(32), .DATA_PERIOD(DP),
    .GAP_CYCLES(GAPC), .TIMEOUT_CYCLES(TMO)
  ) dut_wd (
    .clk_pixel_in(clk), .rst_in(rst), .req_valid_in(valid2), .req_data_in(data2),
    .req_ready_out(ready2), .data_out(sdata2), .data_clk_out(dclk2), .sel_out(sel2),
    .busy_out(busy2), .grant_id_out(gid2), .timeout_out(tmo2)
  );

  int tests = 0;
  int fails = 0;
  int model_last;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Serial line monitor: rebuilds each frame from the wire and logs timing events.
  logic        prev_sel = 1'b1, prev_dclk = 1'b0, prev_busy = 1'b0;
  logic [32:0] cap = '0;
  int          cap_bits = 0;
  logic [32:0] frame_q[$];
  int          bits_q[$];
  int          sel_rise_cyc = 0, busy_fall_cyc = 0, multi_ready = 0;

  always @(negedge clk) begin
    if (!sel && dclk && !prev_dclk) begin
      cap      <= {cap[31:0], sdata};
      cap_bits <= cap_bits + 1;
    end
    if (!sel && prev_sel) begin
      cap      <= '0;
      cap_bits <= 0;
    end
    if (sel && !prev_sel) begin
      frame_q.push_back(cap);
      bits_q.push_back(cap_bits);
      sel_rise_cyc <= cyc;
    end
    if (!busy && prev_busy) busy_fall_cyc <= cyc;
    if ($countones(ready) > 1) multi_ready <= multi_ready + 1;
    prev_sel  <= sel;
    prev_dclk <= dclk;
    prev_busy <= busy;
  end

  function automatic int rr_pick(input int last, input logic [1:0] mask);
    for (int off = 1; off <= NREQ; off++)
      if (mask[(last + off) % NREQ]) return (last + off) % NREQ;
    return -1;
  endfunction

  task automatic wait_ready(output int idx, output int at);
    int n;
    n = 0; idx = -1; at = -1;
    while (ready == 2'b00 && n < 1000) begin @(negedge clk); n++; end
    if (ready != 2'b00) begin idx = ready[1] ? 1 : 0; at = cyc; end
  endtask

  task automatic wait_frame(output logic [32:0] f, output int bits);
    int n;
    n = 0; f = '0; bits = -1;
    while (frame_q.size() == 0 && n < 400) begin @(negedge clk); n++; end
    if (frame_q.size() != 0) begin f = frame_q.pop_front(); bits = bits_q.pop_front(); end
  endtask

  task automatic wait_sel_low();
    int n;
    n = 0;
    while (sel && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || !sel) && n < 500) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; valid = '0; data = '0; valid2 = '0; data2 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests++; if (ready !== 2'b00) begin fails++; $display("FAIL reset_ready: got %b want 00", ready); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests++; if (tmo !== 1'b0) begin fails++; $display("FAIL reset_timeout: got %b want 0", tmo); end
    tests++; if (gid !== 1'b0) begin fails++; $display("FAIL reset_grant_id: got %b want 0", gid); end
    tests++; if (sel !== 1'b1) begin fails++; $display("FAIL reset_sel: got %b want 1", sel); end
    model_last = NREQ - 1;
  endtask

  task automatic test_single();
    int idx, at, bits, exp;
    logic [32:0] f;
    logic [31:0] payload;
    for (int k = 0; k < 2; k++) begin
      payload = (k == 0) ? 32'hDEAD_BEEF : $urandom;
      frame_q.delete(); bits_q.delete();
      data[0] = payload; valid = 2'b01;
      exp = rr_pick(model_last, 2'b01);
      wait_ready(idx, at);
      tests++; if (idx !== exp) begin fails++; $display("FAIL single_grant: got %0d want %0d", idx, exp); end
      tests++; if (int'(gid) !== exp) begin fails++; $display("FAIL single_grant_id: got %0d want %0d", gid, exp); end
      valid = 2'b00;
      @(negedge clk);
      tests++; if (ready !== 2'b00) begin fails++; $display("FAIL single_ready_width: got %b want 00", ready); end
      wait_frame(f, bits);
      tests++; if (bits !== 33) begin fails++; $display("FAIL single_bits: got %0d want 33", bits); end
      tests++; if (f !== {1'b0, payload}) begin fails++; $display("FAIL single_frame: got %h want %h", f, {1'b0, payload}); end
      wait_idle();
      tests++;
      if (busy_fall_cyc - sel_rise_cyc !== GAPC + 1) begin
        fails++; $display("FAIL single_gap: got %0d want %0d", busy_fall_cyc - sel_rise_cyc, GAPC + 1);
      end
      model_last = exp;
    end
  endtask

  task automatic test_contention();
    int idx, at, bits, exp;
    logic [32:0] f, ef;
    rst = 1'b1; repeat (2) @(negedge clk); rst = 1'b0;
    model_last = NREQ - 1;
    frame_q.delete(); bits_q.delete();
    data[0] = $urandom; data[1] = $urandom; valid = 2'b11;
    for (int fr = 0; fr < 4; fr++) begin
      exp = rr_pick(model_last, 2'b11);
      wait_ready(idx, at);
      tests++; if (idx !== exp) begin fails++; $display("FAIL contention_grant%0d: got %0d want %0d", fr, idx, exp); end
      tests++; if (int'(gid) !== exp) begin fails++; $display("FAIL contention_id%0d: got %0d want %0d", fr, gid, exp); end
      ef = {exp[0], data[exp[0]]};
      data[exp[0]] = $urandom;
      @(negedge clk);
      wait_frame(f, bits);
      tests++; if (f !== ef) begin fails++; $display("FAIL contention_frame%0d: got %h want %h", fr, f, ef); end
      model_last = exp;
    end
    valid = 2'b00;
    wait_idle();
  endtask

  task automatic test_late_arrival();
    int idx, at, bits, exp, early, n;
    logic [32:0] f, ef;
    data[0] = $urandom; valid = 2'b01;
    exp = rr_pick(model_last, 2'b01);
    wait_ready(idx, at);
    tests++; if (idx !== exp) begin fails++; $display("FAIL late_first: got %0d want %0d", idx, exp); end
    model_last = exp;
    data[0] = $urandom;
    @(negedge clk);
    wait_sel_low();
    n = 0; while (cap_bits < 5 && n < 100) begin @(negedge clk); n++; end
    data[1] = $urandom; valid = 2'b11;
    early = 0; n = 0;
    while (busy && n < 500) begin if (ready != 2'b00) early++; @(negedge clk); n++; end
    tests++; if (early !== 0) begin fails++; $display("FAIL late_early_ready: got %0d want 0", early); end
    frame_q.delete(); bits_q.delete();
    exp = rr_pick(model_last, 2'b11);
    wait_ready(idx, at);
    tests++; if (idx !== exp) begin fails++; $display("FAIL late_second: got %0d want %0d", idx, exp); end
    ef = {1'b1, data[1]};
    valid = 2'b00;
    model_last = exp;
    @(negedge clk);
    wait_frame(f, bits);
    tests++; if (f !== ef) begin fails++; $display("FAIL late_frame: got %h want %h", f, ef); end
    wait_idle();
  endtask

  task automatic test_withdrawn();
    int idx, at, exp, rdy1, busy_after, n;
    data[0] = $urandom; valid = 2'b01;
    exp = rr_pick(model_last, 2'b01);
    wait_ready(idx, at);
    tests++; if (idx !== exp) begin fails++; $display("FAIL withdrawn_first: got %0d want %0d", idx, exp); end
    model_last = exp;
    valid = 2'b00;
    @(negedge clk);
    wait_sel_low();
    data[1] = $urandom; valid = 2'b10;
    @(negedge clk);
    valid = 2'b00;
    rdy1 = 0; n = 0;
    while (busy && n < 500) begin if (ready[1]) rdy1++; @(negedge clk); n++; end
    busy_after = 0;
    repeat (40) begin if (ready[1]) rdy1++; if (busy) busy_after++; @(negedge clk); end
    tests++; if (rdy1 !== 0) begin fails++; $display("FAIL withdrawn_ready: got %0d want 0", rdy1); end
    tests++; if (busy_after !== 0) begin fails++; $display("FAIL withdrawn_regrant: got %0d want 0", busy_after); end
  endtask

  task automatic test_reset_mid_frame();
    int idx, at, exp, n;
    data[0] = $urandom; valid = 2'b01;
    exp = rr_pick(model_last, 2'b01);
    wait_ready(idx, at);
    tests++; if (idx !== exp) begin fails++; $display("FAIL rst_mid_first: got %0d want %0d", idx, exp); end
    data[0] = $urandom; data[1] = $urandom; valid = 2'b11;
    @(negedge clk);
    wait_sel_low();
    n = 0; while (cap_bits < 10 && n < 100) begin @(negedge clk); n++; end
    rst = 1'b1;
    @(negedge clk);
    tests++; if (sel !== 1'b1) begin fails++; $display("FAIL rst_mid_sel: got %b want 1", sel); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
    tests++; if (ready !== 2'b00) begin fails++; $display("FAIL rst_mid_ready: got %b want 00", ready); end
    rst = 1'b0;
    model_last = NREQ - 1;
    exp = rr_pick(model_last, 2'b11);
    wait_ready(idx, at);
    tests++; if (idx !== exp) begin fails++; $display("FAIL rst_mid_regrant: got %0d want %0d", idx, exp); end
    model_last = exp;
    valid = 2'b00;
    @(negedge clk);
    wait_idle();
  endtask

  task automatic test_timeout();
    int r_at, t_at, b_at, n;
    data2[0] = $urandom; valid2 = 2'b01;
    n = 0; r_at = -1;
    while (ready2 == 2'b00 && n < 200) begin @(negedge clk); n++; end
    tests++; if (ready2 !== 2'b01) begin fails++; $display("FAIL timeout_grant: got %b want 01", ready2); end
    tests++; if (gid2 !== 1'b0) begin fails++; $display("FAIL timeout_grant_id: got %b want 0", gid2); end
    r_at = cyc;
    valid2 = 2'b00;
    @(negedge clk);
    n = 0;
    while (!tmo2 && n < 300) begin @(negedge clk); n++; end
    t_at = cyc;
    tests++; if (t_at - r_at !== TMO + 1) begin fails++; $display("FAIL timeout_latency: got %0d want %0d", t_at - r_at, TMO + 1); end
    tests++; if (busy2 !== 1'b1) begin fails++; $display("FAIL timeout_busy_in_gap: got %b want 1", busy2); end
    @(negedge clk);
    tests++; if (tmo2 !== 1'b0) begin fails++; $display("FAIL timeout_width: got %b want 0", tmo2); end
    tests++;
    if ({sel2, dclk2, sdata2} !== 3'b100) begin
      fails++; $display("FAIL timeout_abort_line: got %b want 100", {sel2, dclk2, sdata2});
    end
    n = 0;
    while (busy2 && n < 100) begin @(negedge clk); n++; end
    b_at = cyc;
    tests++; if (b_at - t_at !== GAPC) begin fails++; $display("FAIL timeout_gap: got %0d want %0d", b_at - t_at, GAPC); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_late_arrival();
    test_withdrawn();
    test_reset_mid_frame();
    test_timeout();
    tests++; if (multi_ready !== 0) begin fails++; $display("FAIL onehot_ready: got %0d multi-bit cycles want 0", multi_ready); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_watchdog: simulation did not finish within time limit");
    $fatal(1, "time limit");
  end

endmodule
